// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared definitions for the 8259A-style interrupt controller:
//               INTA sequencer state encoding, master/slave role constants
//               and the level reported for spurious acknowledge cycles.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEND = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } inta_state_t;

    localparam logic       PIC_MASTER     = 1'b1;
    localparam logic       PIC_SLAVE      = 1'b0;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

endpackage
`default_nettype wire

// File: rtl/inta_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : inta_edge_sync
// Description : Synchronises the asynchronous active-low INTA pin and emits
//               registered single-cycle strobes on its falling and rising
//               edges. Strobe latency is SYNC_STAGES+1 clocks from the pin.
// Ports       : clk, reset_n (async, active-low), inta_n (async pin)
//               ack_fall / ack_rise : one-cycle edge strobes
// Revision    : 1.0 - initial release
// ============================================================================
module inta_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inta_n,
    output logic ack_fall,
    output logic ack_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_fall;
    logic                   r_rise;

    // The chain resets to the pin's inactive (high) level so that leaving
    // reset never manufactures a false falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
            r_last <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], inta_n};
            r_last <= r_sync[SYNC_STAGES-1];
            r_fall <= r_last & ~r_sync[SYNC_STAGES-1];
            r_rise <= ~r_last & r_sync[SYNC_STAGES-1];
        end
    end

    assign ack_fall = r_fall;
    assign ack_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer
// Description : Two-pulse (8086-mode) interrupt-acknowledge sequencer. Raises
//               INT, tracks both INTA pulses, drives/compares CAS[2:0],
//               decides who drives the vector and pulses ISR set/clear.
// Ports       : clk, reset_n (async, active-low), inta_n (async pin)
//               sp_en, sngl, icw2, icw3          : configuration
//               irq_valid, irq_level, cas_in     : resolver / cascade inputs
//               int_out, cas_out, cas_oe         : CPU INT and cascade drive
//               data_out, data_oe                : vector byte and enable
//               isr_set, isr_clr, isr_level      : in-service register pulses
// Config      : define PIC_AEOI_EN to generate auto-EOI isr_clr pulses;
//               otherwise isr_clr is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inta_n,
    input  logic       sp_en,
    input  logic       sngl,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic       irq_valid,
    input  logic [2:0] irq_level,
    input  logic [2:0] cas_in,
    output logic       int_out,
    output logic [2:0] cas_out,
    output logic       cas_oe,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       isr_set,
    output logic       isr_clr,
    output logic [2:0] isr_level
);

    localparam logic [2:0] c_ST_IDLE = IDLE;
    localparam logic [2:0] c_ST_PEND = PEND;
    localparam logic [2:0] c_ST_ACK1 = ACK1;
    localparam logic [2:0] c_ST_GAP  = GAP;
    localparam logic [2:0] c_ST_ACK2 = ACK2;

    logic       w_ack_fall;
    logic       w_ack_rise;
    logic [2:0] r_state;
    logic [2:0] w_next;

    logic       w_enter_ack1;
    logic       w_enter_ack2;
    logic       w_exit_ack2;
    logic       w_spurious;
    logic [2:0] w_lvl;
    logic       w_is_master;
    logic       w_cascaded;
    logic       w_selected;

    logic       r_int_out;
    logic [2:0] r_cas_out;
    logic       r_cas_oe;
    logic [7:0] r_data_out;
    logic       r_data_oe;
    logic       r_isr_set;
    logic [2:0] r_ack_lvl;
    logic       r_cascaded;
    logic       r_selected;

    // Low vector bits come from the acknowledged level, not from ICW2.
    logic       w_unused_icw2;
    assign w_unused_icw2 = ^icw2[2:0];

    inta_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .inta_n   (inta_n),
        .ack_fall (w_ack_fall),
        .ack_rise (w_ack_rise)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_ack_fall)     w_next = c_ST_ACK1;
                else if (irq_valid) w_next = c_ST_PEND;
            end
            c_ST_PEND: begin
                if (w_ack_fall)      w_next = c_ST_ACK1;
                else if (!irq_valid) w_next = c_ST_IDLE;
            end
            c_ST_ACK1: if (w_ack_rise) w_next = c_ST_GAP;
            c_ST_GAP:  if (w_ack_fall) w_next = c_ST_ACK2;
            c_ST_ACK2: if (w_ack_rise) w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    assign w_enter_ack1 = w_ack_fall & ((r_state == c_ST_IDLE) | (r_state == c_ST_PEND));
    assign w_enter_ack2 = w_ack_fall & (r_state == c_ST_GAP);
    assign w_exit_ack2  = w_ack_rise & (r_state == c_ST_ACK2);

    // An acknowledge with no request behind it reports level 7.
    assign w_spurious  = ~irq_valid;
    assign w_lvl       = irq_valid ? irq_level : SPURIOUS_LEVEL;
    // Single mode is a master that has no slaves and never drives CAS.
    assign w_is_master = (sp_en == PIC_MASTER) | sngl;
    assign w_cascaded  = (sp_en == PIC_MASTER) & ~sngl & icw3[w_lvl] & ~w_spurious;
    assign w_selected  = w_is_master | ((sp_en == PIC_SLAVE) & (cas_in == icw3[2:0]));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_int_out  <= 1'b0;
            r_cas_out  <= 3'd0;
            r_cas_oe   <= 1'b0;
            r_data_out <= 8'd0;
            r_data_oe  <= 1'b0;
            r_isr_set  <= 1'b0;
            r_ack_lvl  <= 3'd0;
            r_cascaded <= 1'b0;
            r_selected <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_int_out <= (w_next == c_ST_PEND) & (w_is_master | irq_valid);
            r_isr_set <= 1'b0;

            if (w_enter_ack1) begin
                r_ack_lvl  <= w_lvl;
                r_cascaded <= w_cascaded;
                r_selected <= w_selected;
                r_isr_set  <= w_selected & ~w_spurious;
                r_cas_oe   <= w_cascaded;
                r_cas_out  <= w_cascaded ? w_lvl : 3'd0;
            end

            if (w_enter_ack2) begin
                r_data_out <= {icw2[7:3], r_ack_lvl};
                r_data_oe  <= r_selected & ~r_cascaded;
            end

            if (w_exit_ack2) begin
                r_data_out <= 8'd0;
                r_data_oe  <= 1'b0;
                r_cas_out  <= 3'd0;
                r_cas_oe   <= 1'b0;
            end
        end
    end

`ifdef PIC_AEOI_EN
    logic r_spurious;
    logic r_isr_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spurious <= 1'b0;
            r_isr_clr  <= 1'b0;
        end else begin
            r_isr_clr <= 1'b0;
            if (w_enter_ack1) r_spurious <= w_spurious;
            if (w_exit_ack2)  r_isr_clr  <= r_selected & ~r_spurious;
        end
    end

    assign isr_clr = r_isr_clr;
`else
    assign isr_clr = 1'b0;
`endif

    assign int_out   = r_int_out;
    assign cas_out   = r_cas_out;
    assign cas_oe    = r_cas_oe;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign isr_set   = r_isr_set;
    assign isr_level = r_ack_lvl;

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
# inta_sequencer

Clocked interrupt-acknowledge sequencer for the 8259A PIC. It tracks the two-pulse 8086-mode INTA cycle, raises INT toward the CPU, and drives or compares the cascade lines CAS[2:0]. It decides whether this device or a cascaded slave places the vector on the data bus, and emits ISR set and (optionally) auto-EOI clear pulses to the in-service register. It sits between the priority resolver, the ICW/OCW register file and the cascade/data-bus buffers.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `inta_n`, minimum 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `inta_n`  in  1  CPU interrupt acknowledge, asynchronous, active-low.
- `sp_en`  in  1  1 = master, 0 = slave.
- `sngl`  in  1  ICW1 SNGL; 1 = no cascade, master behaviour with no slaves.
- `icw2`  in  8  vector base; bits [7:3] are used.
- `icw3`  in  8  master: slave-present mask per IR; slave: bits [2:0] are the slave ID.
- `irq_valid`  in  1  priority resolver has a winning request.
- `irq_level`  in  3  winning IR level.
- `cas_in`  in  3  sampled CAS lines (slave).
- `int_out`  out  1  INT to CPU.
- `cas_out`  out  3  CAS value driven (master).
- `cas_oe`  out  1  CAS output enable.
- `data_out`  out  8  vector byte.
- `data_oe`  out  1  data-bus output enable.
- `isr_set`  out  1  one-cycle pulse: set ISR bit `isr_level`.
- `isr_clr`  out  1  one-cycle pulse: clear ISR bit `isr_level` (auto-EOI).
- `isr_level`  out  3  level for `isr_set` and `isr_clr`.

## Operation
- `inta_n` passes through `SYNC_STAGES` flops. `ack_fall` and `ack_rise` are single-cycle edge strobes on the synchronised signal.
- FSM states: IDLE, PEND, ACK1, GAP, ACK2.
  - IDLE → PEND when `irq_valid`.
  - PEND → IDLE when `irq_valid` drops before `ack_fall`.
  - IDLE or PEND → ACK1 on `ack_fall`.
  - ACK1 → GAP on `ack_rise`.
  - GAP → ACK2 on `ack_fall`.
  - ACK2 → IDLE on `ack_rise`.
- `int_out` = 1 in PEND only, and only when `sp_en` or `sngl` is set or the device is a slave with a request. It drops on the cycle ACK1 is entered.
- On entering ACK1, `ack_lvl` latches `irq_level` when `irq_valid`=1. Otherwise the cycle is spurious: `ack_lvl`=7 and `isr_set` is suppressed.
- Master (`sp_en`=1, `sngl`=0) entering ACK1:
  - `cascaded` = `icw3[ack_lvl]` & ~spurious.
  - If `cascaded`: `cas_out`=`ack_lvl` and `cas_oe`=1 from ACK1 entry until ACK2 exit.
  - `isr_set` pulses with `isr_level`=`ack_lvl`.
- Slave (`sp_en`=0) entering ACK1:
  - `selected` = (`cas_in` == `icw3[2:0]`), sampled on that cycle.
  - If not selected, the slave ignores the rest of the cycle: no `isr_set`, `data_oe` stays 0, and its request stays pending.
- Single mode (`sngl`=1) behaves as a master with all `icw3` bits 0. `cas_oe` is never asserted.
- ACK2: `data_out` = {`icw2[7:3]`, `ack_lvl`}. `data_oe`=1 for the whole state if the device is a master or single with `cascaded`=0, or a selected slave. Otherwise `data_oe`=0.
- `inta_n` falling in GAP is ACK2 even if `irq_valid` has changed; `ack_lvl` is never re-latched in GAP.
- Reset, at any time including mid-cycle: state IDLE, and every output is 0 (`int_out`, `cas_out`, `cas_oe`, `data_out`, `data_oe`, `isr_set`, `isr_clr`, `isr_level`).

## Timing
- Pin-to-strobe latency: `SYNC_STAGES`+1 clocks from the `inta_n` edge to `ack_fall`/`ack_rise`. All outputs are registered and change on the clock edge after the strobe.
- `isr_set` is one cycle wide and coincides with the first cycle of ACK1.
- `isr_clr` is one cycle wide on the first cycle of IDLE after ACK2.
- `data_oe` deasserts on the same clock on which the ACK2 → IDLE transition occurs.
- `cas_oe` deasserts on the same clock on which the ACK2 → IDLE transition occurs.
- INTA pulses shorter than `SYNC_STAGES`+1 clocks are not required to be detected.

## Configuration
- `PIC_AEOI_EN` defined: `isr_clr` pulses after ACK2 with `isr_level`=`ack_lvl`. It is suppressed for spurious cycles and for unselected slaves.
- `PIC_AEOI_EN` undefined: the `isr_clr` port still exists and is tied to 0. No AEOI logic is synthesised.

## Structure
- Shared package `pic_pkg` holds:
  - `inta_state_t` enum: IDLE, PEND, ACK1, GAP, ACK2.
  - Constants `PIC_MASTER`=1'b1 and `PIC_SLAVE`=1'b0.
  - `SPURIOUS_LEVEL`=3'd7.
- Sub-module `inta_edge_sync`: `SYNC_STAGES` synchroniser on `inta_n` plus edge detector producing `ack_fall` and `ack_rise`.

## Test plan
- Master, `sngl`=1, `icw2`=8'h40, request `irq_level`=3 → `int_out` high; on the two INTA pulses, `isr_set`@3 during ACK1 and `data_out`=8'h43 with `data_oe`=1 in ACK2.
- Master, `sngl`=0, `icw3`=8'h04, request at level 2 → `cas_out`=3'd2 with `cas_oe`=1 across both pulses; `data_oe` stays 0; `isr_set`@2.
- Slave, `icw3`=8'h02, `icw2`=8'h70, `cas_in`=2 at ACK1 → `isr_set`@`irq_level`, `data_out`=8'h70|level in ACK2. Repeat with `cas_in`=5 → no `isr_set`, `data_oe`=0.
- `irq_valid` drops one cycle before the first INTA → spurious cycle: `data_out`=8'h47 (`icw2`=8'h40), no `isr_set`, no `isr_clr`.
- `reset_n` asserted during GAP → all outputs 0 immediately and state IDLE. Next full cycle behaves normally.
- With `PIC_AEOI_EN`, level 5 acknowledged → `isr_clr`@5 exactly one cycle after ACK2 exit. Without the macro, `isr_clr` stays 0.
